mem_bus_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-port synchronous data memory (64 x 16 by default). It shares the memory between requester 0 (the CPU's MAR/MDR path) and requester 1 (program loader / debug port). It owns `mem_addr`, `mem_we` and `mem_data`, sequences the memory's one-cycle read latency and returns read data with a valid pulse. It sits between the two requesters and the memory instance at top level.

---
 rtl/mem_bus_arbiter_pkg.sv | 19 +
 rtl/mem_bus_arbiter_rr_arbiter2.sv | 42 ++++
 rtl/mem_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
// Shared definitions for the data-memory arbiter.
//   state_t          : sequencer states (IDLE, WRITE, RD_WAIT, RD_CAP)
//   PORT_CPU/LOADER  : requester indices used for the grant pointer and owner tag
//   NUM_PORTS        : number of requesters sharing the memory
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RD_CAP  = 2'd3
  } state_t;

  localparam logic PORT_CPU    = 1'b0;
  localparam logic PORT_LOADER = 1'b1;
  localparam int   NUM_PORTS   = 2;

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// rr_arbiter2
// Two-way round-robin winner select.
//   clk, rst      : clock, asynchronous active-high reset
//   req0, req1    : request lines
//   advance       : strobe - the current winner has been granted
//   win_valid     : at least one request is pending
//   win_port      : index of the winning port (combinational)
// The pointer remembers the last granted port; on a tie the other port wins.
module rr_arbiter2
  import mem_bus_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  output logic win_valid,
  output logic win_port
);

  logic last_reg;

  always_comb begin
    win_valid = req0 | req1;
    win_port  = PORT_CPU;
    if (req0 && req1) begin
      win_port = ~last_reg;
    end else if (req1) begin
      win_port = PORT_LOADER;
    end
  end

  // Reset to the loader so the CPU wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_reg <= PORT_LOADER;
    end else if (advance) begin
      last_reg <= win_port;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares a single-port synchronous memory between the CPU (port 0) and the
// loader/debug port (port 1), sequences the one-cycle read latency and
// returns read data with a per-port valid pulse.
//   clk, rst                 : clock, asynchronous active-high reset
//   req*/we*/addr*/wdata*    : per-port command, held until gnt*
//   gnt*                     : one-cycle pulse, command captured
//   rvalid*                  : one-cycle pulse, rdata holds this port's word
//   rdata                    : last captured read word (shared)
//   busy                     : sequencer not idle
//   mem_in                   : memory read data
//   mem_addr/mem_we/mem_data : registered memory command
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  input  logic [DATA_WIDTH-1:0] mem_in,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_data
);

  state_t                  state_reg;
  logic                    owner_reg;
  logic [NUM_PORTS-1:0]    gnt_reg;
  logic [NUM_PORTS-1:0]    rvalid_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;
  logic [ADDR_WIDTH-1:0]   mem_addr_reg;
  logic                    mem_we_reg;
  logic [DATA_WIDTH-1:0]   mem_data_reg;

  logic                    win_valid;
  logic                    win_port;
  logic                    advance;

  // Per-port command buses gathered into arrays so the winner can index them.
  logic                    we_arr    [NUM_PORTS];
  logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0]   wdata_arr [NUM_PORTS];

  assign we_arr[0]    = we0;
  assign we_arr[1]    = we1;
  assign addr_arr[0]  = addr0;
  assign addr_arr[1]  = addr1;
  assign wdata_arr[0] = wdata0;
  assign wdata_arr[1] = wdata1;

  // Arbitration only happens in IDLE; the pointer moves with each grant.
  assign advance = (state_reg == ST_IDLE) && win_valid;

  rr_arbiter2 u_rr_arbiter2 (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .advance   (advance),
    .win_valid (win_valid),
    .win_port  (win_port)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      owner_reg    <= PORT_CPU;
      gnt_reg      <= '0;
      rvalid_reg   <= '0;
      rdata_reg    <= '0;
      mem_addr_reg <= '0;
      mem_we_reg   <= 1'b0;
      mem_data_reg <= '0;
    end else begin
      gnt_reg    <= '0;
      rvalid_reg <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (win_valid) begin
            gnt_reg[win_port] <= 1'b1;
            owner_reg         <= win_port;
            mem_addr_reg      <= addr_arr[win_port];
            mem_data_reg      <= wdata_arr[win_port];
            if (we_arr[win_port]) begin
              mem_we_reg <= 1'b1;
              state_reg  <= ST_WRITE;
            end else begin
              state_reg  <= ST_RD_WAIT;
            end
          end
        end
        ST_WRITE: begin
          mem_we_reg <= 1'b0;
          state_reg  <= ST_IDLE;
        end
        // Memory samples mem_addr during this cycle; data appears next cycle.
        ST_RD_WAIT: begin
          state_reg <= ST_RD_CAP;
        end
        ST_RD_CAP: begin
          rdata_reg             <= mem_in;
          rvalid_reg[owner_reg] <= 1'b1;
          state_reg             <= ST_IDLE;
        end
        default: begin
          mem_we_reg <= 1'b0;
          state_reg  <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt0     = gnt_reg[0];
  assign gnt1     = gnt_reg[1];
  assign rvalid0  = rvalid_reg[0];
  assign rvalid1  = rvalid_reg[1];
  assign rdata    = rdata_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign mem_addr = mem_addr_reg;
  assign mem_we   = mem_we_reg;
  assign mem_data = mem_data_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// Directed bench: a vector table of single transactions plus hand-written
// sequences for contention, late requests, withdrawn requests and reset
// during a transfer. A simple synchronous memory model sits on the mem bus.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [5:0]  addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, busy, mem_we;
  logic [15:0] rdata, mem_data, mem_in;
  logic [5:0]  mem_addr;

  int total = 0;
  int bad   = 0;
  logic [15:0] last_rd = 16'h0000;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy), .mem_in(mem_in),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_data(mem_data)
  );

  // Single-port synchronous memory, one-cycle read latency.
  logic [15:0] mem [64];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
    mem_in <= mem[mem_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [5:0] a, input logic [15:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  function automatic logic gnt_of(input int p);
    return (p == 0) ? gnt0 : gnt1;
  endfunction

  function automatic logic rv_of(input int p);
    return (p == 0) ? rvalid0 : rvalid1;
  endfunction

  task automatic wait_gnt(input int p, input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (gnt_of(p)) begin n = i; break; end
    end
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [5:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [8];

  // Called at a negedge with the sequencer idle; returns at a negedge, idle.
  task automatic run_txn(input vec_t v);
    int n;
    set_port(v.port, 1'b1, v.we, v.addr, v.data);
    chk("no_comb_gnt", {31'd0, gnt_of(v.port)}, 32'd0);
    wait_gnt(v.port, 6, n);
    chk("gnt_latency", n, 32'd1);
    chk("gnt_other", {31'd0, gnt_of(1 - v.port)}, 32'd0);
    chk("mem_addr", {26'd0, mem_addr}, {26'd0, v.addr});
    chk("mem_we_grant", {31'd0, mem_we}, {31'd0, v.we});
    chk("busy_grant", {31'd0, busy}, 32'd1);
    if (v.we) chk("mem_data", {16'd0, mem_data}, {16'd0, v.data});
    set_port(v.port, 1'b0, 1'b0, 6'd0, 16'd0);
    if (v.we) begin
      @(negedge clk);
      chk("mem_we_drop", {31'd0, mem_we}, 32'd0);
      chk("busy_write_end", {31'd0, busy}, 32'd0);
      chk("rdata_held", {16'd0, rdata}, {16'd0, last_rd});
    end else begin
      @(negedge clk);
      chk("rvalid_early", {31'd0, rv_of(v.port)}, 32'd0);
      @(negedge clk);
      chk("rvalid", {31'd0, rv_of(v.port)}, 32'd1);
      chk("rvalid_other", {31'd0, rv_of(1 - v.port)}, 32'd0);
      chk("rdata", {16'd0, rdata}, {16'd0, v.exp});
      chk("busy_read_end", {31'd0, busy}, 32'd0);
      last_rd = v.exp;
    end
    $display("txn port=%0d we=%0d addr=%02h data=%04h rdata=%04h",
             v.port, v.we, v.addr, v.data, rdata);
  endtask

  initial begin
    int n, cnt, at, rv_at, ng, nwe;
    int order [4];

    vecs[0] = '{0, 1'b1, 6'h0A, 16'hBEEF, 16'h0000};
    vecs[1] = '{1, 1'b0, 6'h0A, 16'h0000, 16'hBEEF};
    vecs[2] = '{1, 1'b1, 6'h01, 16'h0F0F, 16'h0000};
    vecs[3] = '{0, 1'b0, 6'h01, 16'h0000, 16'h0F0F};
    vecs[4] = '{0, 1'b1, 6'h3F, 16'hA5A5, 16'h0000};
    vecs[5] = '{1, 1'b0, 6'h3F, 16'h0000, 16'hA5A5};
    vecs[6] = '{1, 1'b1, 6'h00, 16'hC3C3, 16'h0000};
    vecs[7] = '{0, 1'b0, 6'h00, 16'h0000, 16'hC3C3};

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_outputs", {gnt0, gnt1, rvalid0, rvalid1, busy, mem_we}, 32'd0);
    chk("rst_bus", {mem_addr, mem_data}, 32'd0);
    chk("rst_rdata", {16'd0, rdata}, 32'd0);
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("idle_outputs", {gnt0, gnt1, rvalid0, rvalid1, busy, mem_we, rdata}, 32'd0);
    $display("reset check done");

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Continuous contention from a fresh reset: expect 0,1,0,1
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    last_rd = 16'h0000;
    set_port(0, 1'b1, 1'b0, 6'h01, 16'h0000);
    set_port(1, 1'b1, 1'b1, 6'h02, 16'h1234);
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 4; i++) begin
      @(negedge clk);
      if (gnt0 && gnt1) chk("dual_gnt", 32'd1, 32'd0);
      if (rvalid0) chk("contention_rdata", {16'd0, rdata}, 32'h0F0F);
      if (gnt0) begin order[cnt] = 0; cnt++; end
      else if (gnt1) begin order[cnt] = 1; cnt++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("contention_count", cnt, 32'd4);
    for (int i = 0; i < 4; i++) chk("contention_order", order[i], i % 2);
    for (int i = 0; i < 4; i++) @(negedge clk);
    $display("contention order %0d %0d %0d %0d", order[0], order[1], order[2], order[3]);

    // Request raised while a port 0 read is in RD_WAIT
    set_port(0, 1'b1, 1'b0, 6'h0A, 16'h0000);
    wait_gnt(0, 6, n);
    chk("late_gnt0", n, 32'd1);
    set_port(0, 1'b0, 1'b0, 6'h00, 16'h0000);
    set_port(1, 1'b1, 1'b1, 6'h05, 16'h1111);
    cnt = 0; at = -1; rv_at = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (rvalid0) begin rv_at = i; chk("late_rdata", {16'd0, rdata}, 32'hBEEF); end
      if (gnt1) begin cnt++; at = i; set_port(1, 1'b0, 1'b0, 6'h00, 16'h0000); end
    end
    chk("late_rvalid0_at", rv_at, 32'd2);
    chk("late_gnt1_count", cnt, 32'd1);
    chk("late_gnt1_at", at, 32'd3);
    $display("late request gnt1 at %0d, rvalid0 at %0d", at, rv_at);

    // Withdrawn request during a port 1 read is never served
    set_port(1, 1'b1, 1'b0, 6'h0A, 16'h0000);
    wait_gnt(1, 6, n);
    chk("pulse_gnt1", n, 32'd1);
    set_port(1, 1'b0, 1'b0, 6'h00, 16'h0000);
    set_port(0, 1'b1, 1'b1, 6'h0A, 16'hDEAD);
    ng = 0; nwe = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) set_port(0, 1'b0, 1'b0, 6'h00, 16'h0000);
      if (gnt0) ng++;
      if (mem_we) nwe++;
      if (rvalid1) chk("pulse_rdata", {16'd0, rdata}, 32'hBEEF);
    end
    chk("pulse_no_gnt0", ng, 32'd0);
    chk("pulse_no_write", nwe, 32'd0);
    last_rd = 16'hBEEF;
    run_txn('{0, 1'b0, 6'h0A, 16'h0000, 16'hBEEF});

    // Reset during a write grant: mem_we drops at once, write never lands
    set_port(0, 1'b1, 1'b1, 6'h0A, 16'h7777);
    wait_gnt(0, 6, n);
    chk("rstw_mem_we_before", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    set_port(0, 1'b0, 1'b0, 6'h00, 16'h0000);
    #1;
    chk("rstw_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rstw_busy_gnt", {30'd0, busy, gnt0}, 32'd0);
    @(negedge clk); rst = 1'b0;
    nwe = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (mem_we || gnt0 || gnt1) nwe++; end
    chk("rstw_quiet", nwe, 32'd0);
    $display("reset during write done");

    // Reset during RD_CAP of a port 0 read: no rvalid0
    set_port(0, 1'b1, 1'b0, 6'h0A, 16'h0000);
    wait_gnt(0, 6, n);
    set_port(0, 1'b0, 1'b0, 6'h00, 16'h0000);
    @(negedge clk);
    chk("rstr_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstr_busy", {31'd0, busy}, 32'd0);
    chk("rstr_mem_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (rvalid0 || rvalid1) cnt++; end
    chk("rstr_no_rvalid", cnt, 32'd0);
    chk("rstr_rdata", {16'd0, rdata}, 32'd0);
    $display("reset during read done");

    // First tie after reset goes to port 0; interrupted write left 0A intact
    set_port(0, 1'b1, 1'b0, 6'h0A, 16'h0000);
    set_port(1, 1'b1, 1'b0, 6'h05, 16'h0000);
    at = -1;
    for (int i = 0; i < 6 && at < 0; i++) begin
      @(negedge clk);
      if (gnt0) at = 0; else if (gnt1) at = 1;
    end
    chk("tie_first", at, 32'd0);
    set_port(0, 1'b0, 1'b0, 6'h00, 16'h0000);
    @(negedge clk); @(negedge clk);
    chk("tie_rvalid0", {31'd0, rvalid0}, 32'd1);
    chk("tie_rdata0", {16'd0, rdata}, 32'hBEEF);
    wait_gnt(1, 6, n);
    chk("tie_gnt1", n, 32'd1);
    set_port(1, 1'b0, 1'b0, 6'h00, 16'h0000);
    @(negedge clk); @(negedge clk);
    chk("tie_rvalid1", {31'd0, rvalid1}, 32'd1);
    chk("tie_rdata1", {16'd0, rdata}, 32'h1111);
    $display("tie after reset first=%0d", at);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
